spi_master_ctrl: RTL and testbench
==================================

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 2, number of clk cycles per sclk half-period; legal range 1..255.
REQ-002 Parameter SS_GAP, default 2, minimum clk cycles ss stays high between frames; legal range 1..255.
REQ-003 The block SHALL provide port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 The block SHALL provide port rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 The block SHALL provide port start  input  1  frame request, sampled on clk.
REQ-006 The block SHALL provide port tx_data  input  8  byte to transmit, MSB first.
REQ-007 The block SHALL provide port miso  input  1  serial data from the SPI slave.
REQ-008 The block SHALL provide port sclk  output  1  SPI clock, mode 0 (idle low).
REQ-009 The block SHALL provide port mosi  output  1  serial data to the slave.
REQ-010 The block SHALL provide port ss  output  1  active-low slave select.
REQ-011 The block SHALL provide port busy  output  1  high while a frame or the SS_GAP interval is in progress.
REQ-012 The block SHALL provide port done  output  1  one-cycle pulse at frame completion.
REQ-013 The block SHALL provide port rx_data  output  8  last received byte, MSB first.

Function
REQ-014 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-015 FSM states SHALL be IDLE, SETUP, XFER, HOLD, GAP.
REQ-016 In IDLE with start=1, tx_data SHALL be latched at that edge (cycle 0); start in any other state SHALL be ignored.
REQ-017 At cycle 1: state SETUP, ss=0, busy=1, mosi=tx_data[7], sclk=0.
REQ-018 sclk SHALL rise at cycles 1+(2k+1)*CLK_DIV and fall at cycles 1+(2k+2)*CLK_DIV, k=0..7: exactly 8 rising and 8 falling edges per frame.
REQ-019 On the clk edge where sclk goes 0->1, miso SHALL be shifted into the rx shift register LSB (first sample = bit 7).
REQ-020 On falling edges 1..7, mosi SHALL advance to tx bits 6..0 respectively; after the 8th fall mosi SHALL hold bit 0 until ss rises, then go 0.
REQ-021 After the 8th fall, state HOLD SHALL keep ss=0, sclk=0 for CLK_DIV cycles; ss SHALL rise at cycle 1+17*CLK_DIV.
REQ-022 At the cycle ss rises: rx_data SHALL load the 8 sampled bits and done SHALL be 1 for exactly that cycle.
REQ-023 GAP SHALL hold ss=1, busy=1 for SS_GAP cycles after ss rises; busy SHALL then drop and the FSM return to IDLE.
REQ-024 A start asserted in the first cycle busy=0 SHALL be accepted (back-to-back frames, ss high for exactly SS_GAP cycles).
REQ-025 The half-period counter SHALL be 8 bits, reload to CLK_DIV-1, never wrap mid-phase; the bit counter SHALL be 3 bits and end the frame at wrap from 7.
REQ-026 rx_data SHALL change only at done; tx_data changes during a frame SHALL not affect mosi.

Reset
REQ-027 rst=0 SHALL asynchronously force: state IDLE, ss=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0x00, counters 0.
REQ-028 Reset mid-frame SHALL abort immediately without a done pulse; the first start after rst release SHALL produce a complete normal frame.

Verification (CLK_DIV=2, SS_GAP=2 unless stated)
REQ-029 Hold rst=0 -> ss=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0x00 without any clk edge.
REQ-030 start with tx_data=0xA5, bench slave model returns 0x3C (bit7 valid before first rise, shifts on falls) -> mosi at rises = 1,0,1,0,0,1,0,1; ss low exactly 34 cycles; done at cycle 35; rx_data=0x3C.
REQ-031 start held high for an entire frame with tx_data=0xFF -> second frame begins exactly 2 cycles after ss rises; ss high exactly 2 cycles between frames; two done pulses.
REQ-032 start pulsed again at cycle 10 of a frame -> ignored; only one frame, one done.
REQ-033 rst=0 at the 5th sclk rise -> immediate idle outputs, no done, rx_data=0x00; next start with 0x5A completes normally.
REQ-034 CLK_DIV=1, tx_data=0x81, miso tied 1 -> sclk period 2 cycles, ss low 17 cycles, rx_data=0xFF.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// spi_master_ctrl
// Single-byte SPI master, mode 0 (sclk idles low, data sampled on the rising
// edge, changed on the falling edge), MSB first.
//
// Parameters
//   CLK_DIV  clk cycles per sclk half-period (1..255)
//   SS_GAP   clk cycles ss stays high between frames (1..255)
//
// Ports
//   clk      system clock, all state changes on its rising edge
//   rst      asynchronous active-low reset
//   start    frame request, only honoured in IDLE
//   tx_data  byte to send; captured at the cycle start is accepted
//   miso     serial data from the slave
//   sclk     SPI clock
//   mosi     serial data to the slave
//   ss       active-low slave select
//   busy     high from frame start until the FSM returns to IDLE
//   done     one-cycle pulse on the cycle ss rises
//   rx_data  last received byte, updated only together with done
// -----------------------------------------------------------------------------
module spi_master_ctrl #(
    parameter int CLK_DIV = 2,
    parameter int SS_GAP  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_data,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       ss,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        GAP
    } state_t;

    localparam logic [7:0] HALF_RELOAD = 8'(CLK_DIV - 1);
    // The cycle ss rises and the first IDLE cycle both count toward the
    // high time of ss, so GAP itself lasts SS_GAP-1 cycles. That lets a start
    // sampled in the first non-busy cycle give exactly SS_GAP cycles of ss high.
    localparam logic [7:0] GAP_RELOAD  = 8'((SS_GAP >= 2) ? (SS_GAP - 2) : 0);

    state_t      state_reg;
    logic [7:0]  half_cnt_reg;
    logic [2:0]  bit_cnt_reg;
    logic [7:0]  gap_cnt_reg;
    logic [7:0]  tx_sr_reg;
    logic [7:0]  rx_sr_reg;
    logic        sclk_reg;
    logic        mosi_reg;
    logic        ss_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [7:0]  rx_data_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            half_cnt_reg <= 8'd0;
            bit_cnt_reg  <= 3'd0;
            gap_cnt_reg  <= 8'd0;
            tx_sr_reg    <= 8'd0;
            rx_sr_reg    <= 8'd0;
            sclk_reg     <= 1'b0;
            mosi_reg     <= 1'b0;
            ss_reg       <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            rx_data_reg  <= 8'd0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg    <= SETUP;
                        tx_sr_reg    <= tx_data;
                        mosi_reg     <= tx_data[7];
                        ss_reg       <= 1'b0;
                        busy_reg     <= 1'b1;
                        half_cnt_reg <= HALF_RELOAD;
                        bit_cnt_reg  <= 3'd0;
                    end
                end

                // First half-period with ss low: slave sees bit 7 before the
                // first rising edge.
                SETUP: begin
                    if (half_cnt_reg == 8'd0) begin
                        sclk_reg     <= 1'b1;
                        rx_sr_reg    <= {rx_sr_reg[6:0], miso};
                        half_cnt_reg <= HALF_RELOAD;
                        state_reg    <= XFER;
                    end else begin
                        half_cnt_reg <= half_cnt_reg - 8'd1;
                    end
                end

                XFER: begin
                    if (half_cnt_reg == 8'd0) begin
                        half_cnt_reg <= HALF_RELOAD;
                        sclk_reg     <= ~sclk_reg;
                        if (sclk_reg) begin
                            // Falling edge: advance the bit counter; the
                            // eighth fall (wrap from 7) ends the data phase
                            // with mosi left on bit 0.
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            if (bit_cnt_reg == 3'd7) begin
                                state_reg <= HOLD;
                            end else begin
                                tx_sr_reg <= {tx_sr_reg[6:0], 1'b0};
                                mosi_reg  <= tx_sr_reg[6];
                            end
                        end else begin
                            rx_sr_reg <= {rx_sr_reg[6:0], miso};
                        end
                    end else begin
                        half_cnt_reg <= half_cnt_reg - 8'd1;
                    end
                end

                HOLD: begin
                    if (half_cnt_reg == 8'd0) begin
                        ss_reg      <= 1'b1;
                        mosi_reg    <= 1'b0;
                        done_reg    <= 1'b1;
                        rx_data_reg <= rx_sr_reg;
                        if (SS_GAP > 1) begin
                            state_reg   <= GAP;
                            gap_cnt_reg <= GAP_RELOAD;
                        end else begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end else begin
                        half_cnt_reg <= half_cnt_reg - 8'd1;
                    end
                end

                GAP: begin
                    if (gap_cnt_reg == 8'd0) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - 8'd1;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign sclk    = sclk_reg;
    assign mosi    = mosi_reg;
    assign ss      = ss_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign rx_data = rx_data_reg;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_master_ctrl
// Directed bench for spi_master_ctrl. One instance runs CLK_DIV=2/SS_GAP=2
// against a mode-0 slave model; a second instance runs CLK_DIV=1 with miso
// tied high. All checks go through chk().
// -----------------------------------------------------------------------------
module tb_spi_master_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic [7:0] tx_data;
    logic       miso;
    logic       sclk, mosi, ss, busy, done;
    logic [7:0] rx_data;

    logic       start1;
    logic [7:0] tx1;
    logic       miso1;
    logic       sclk1, mosi1, ss1, busy1, done1;
    logic [7:0] rx1;

    assign miso1 = 1'b1;

    spi_master_ctrl #(.CLK_DIV(2), .SS_GAP(2)) dut (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .miso(miso),
        .sclk(sclk), .mosi(mosi), .ss(ss), .busy(busy), .done(done), .rx_data(rx_data)
    );

    spi_master_ctrl #(.CLK_DIV(1), .SS_GAP(2)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .tx_data(tx1), .miso(miso1),
        .sclk(sclk1), .mosi(mosi1), .ss(ss1), .busy(busy1), .done(done1), .rx_data(rx1)
    );

    int checks = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- slave model + monitor for dut ----------------
    logic [7:0] slv_byte = 8'h00;
    logic [7:0] slv_sr   = 8'h00;
    logic       sclk_q   = 1'b0;
    logic       ss_q     = 1'b1;
    logic [7:0] mosi_bits;
    int rises, done_cnt, frames, low_cnt, high_cnt, last_low, last_high;
    logic done_at_rise;

    initial miso = 1'b0;

    always @(negedge clk) begin
        if (!ss && ss_q) begin
            frames++;
            last_high = high_cnt;
            slv_sr    = slv_byte;
            miso      = slv_byte[7];
        end
        if (ss && !ss_q) begin
            last_low     = low_cnt;
            done_at_rise = done;
        end
        if (sclk && !sclk_q) begin
            rises++;
            mosi_bits = {mosi_bits[6:0], mosi};
        end
        if (!sclk && sclk_q) begin
            slv_sr = {slv_sr[6:0], 1'b0};
            miso   = slv_sr[7];
        end
        if (done) done_cnt++;
        if (ss) begin high_cnt++; low_cnt = 0; end
        else    begin low_cnt++;  high_cnt = 0; end
        sclk_q = sclk;
        ss_q   = ss;
    end

    task automatic clear_mon();
        rises = 0; done_cnt = 0; frames = 0; last_low = 0; last_high = 0;
        mosi_bits = 8'h00; done_at_rise = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int target);
        int n = 0;
        while (done_cnt < target && n < 300) begin step(); n++; end
        chk(tag, 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic pulse_start(input logic [7:0] d);
        @(negedge clk);
        tx_data = d;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    initial begin
        logic [7:0] bits1;
        int low1, nrise1, last_rise1, d1;
        logic s_prev;

        rst = 1'b1; start = 1'b0; tx_data = 8'h00; start1 = 1'b0; tx1 = 8'h00;
        clear_mon();
        high_cnt = 0; low_cnt = 0;

        // Reset asserted before any clock edge.
        #1 rst = 1'b0;
        #1;
        chk("rst_ss",   32'(ss),      32'd1);
        chk("rst_sclk", 32'(sclk),    32'd0);
        chk("rst_mosi", 32'(mosi),    32'd0);
        chk("rst_busy", 32'(busy),    32'd0);
        chk("rst_done", 32'(done),    32'd0);
        chk("rst_rx",   32'(rx_data), 32'h00);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame: 0xA5 out, slave returns 0x3C; tx_data changed mid-frame.
        slv_byte = 8'h3C;
        clear_mon();
        pulse_start(8'hA5);
        tx_data = 8'h00;
        chk("a5_busy", 32'(busy), 32'd1);
        repeat (10) @(negedge clk);
        chk("a5_rx_mid", 32'(rx_data), 32'h00);
        wait_done("a5_done_wait", 1);
        chk("a5_ss_low",    32'(last_low),     32'd34);
        chk("a5_done_rise", 32'(done_at_rise), 32'd1);
        chk("a5_mosi",      32'(mosi_bits),    32'hA5);
        chk("a5_rises",     32'(rises),        32'd8);
        chk("a5_rx",        32'(rx_data),      32'h3C);
        repeat (6) step();
        chk("a5_idle_busy", 32'(busy),     32'd0);
        chk("a5_idle_mosi", 32'(mosi),     32'd0);
        chk("a5_done_cnt",  32'(done_cnt), 32'd1);

        // start held high: back-to-back frames with exactly 2 cycles of ss high.
        slv_byte = 8'h96;
        clear_mon();
        @(negedge clk);
        tx_data = 8'hFF;
        start   = 1'b1;
        wait_done("b2b_done1_wait", 1);
        begin
            int n = 0;
            while (ss && n < 20) begin step(); n++; end
        end
        start = 1'b0;
        chk("b2b_ss_high", 32'(last_high), 32'd2);
        wait_done("b2b_done2_wait", 2);
        repeat (8) step();
        chk("b2b_frames", 32'(frames),    32'd2);
        chk("b2b_dones",  32'(done_cnt),  32'd2);
        chk("b2b_mosi",   32'(mosi_bits), 32'hFF);
        chk("b2b_rx",     32'(rx_data),   32'h96);

        // start pulsed again at cycle 10 of a frame is ignored.
        slv_byte = 8'h5A;
        clear_mon();
        pulse_start(8'h33);
        repeat (9) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (60) step();
        chk("ign_frames", 32'(frames),    32'd1);
        chk("ign_dones",  32'(done_cnt),  32'd1);
        chk("ign_mosi",   32'(mosi_bits), 32'h33);
        chk("ign_rx",     32'(rx_data),   32'h5A);

        // Reset at the 5th sclk rise aborts without done.
        slv_byte = 8'hC3;
        clear_mon();
        pulse_start(8'h0F);
        begin
            int n = 0;
            while (rises < 5 && n < 100) begin step(); n++; end
            chk("abort_reach_rise5", 32'(rises), 32'd5);
        end
        rst = 1'b0;
        #1;
        chk("abort_ss",   32'(ss),      32'd1);
        chk("abort_sclk", 32'(sclk),    32'd0);
        chk("abort_mosi", 32'(mosi),    32'd0);
        chk("abort_busy", 32'(busy),    32'd0);
        chk("abort_done", 32'(done),    32'd0);
        chk("abort_rx",   32'(rx_data), 32'h00);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (40) step();
        chk("abort_no_done", 32'(done_cnt), 32'd0);

        clear_mon();
        pulse_start(8'h5A);
        wait_done("post_rst_done_wait", 1);
        chk("post_rst_ss_low", 32'(last_low),  32'd34);
        chk("post_rst_mosi",   32'(mosi_bits), 32'h5A);
        chk("post_rst_rx",     32'(rx_data),   32'hC3);

        // CLK_DIV=1 instance, miso tied high.
        @(negedge clk);
        tx1    = 8'h81;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        low1 = 0; nrise1 = 0; last_rise1 = 0; d1 = 0; bits1 = 8'h00;
        s_prev = sclk1;
        for (int c = 1; c < 60; c++) begin
            if (!ss1) low1++;
            if (sclk1 && !s_prev) begin
                if (nrise1 > 0) chk("div1_period", 32'(c - last_rise1), 32'd2);
                last_rise1 = c;
                nrise1++;
                bits1 = {bits1[6:0], mosi1};
            end
            if (done1) d1++;
            s_prev = sclk1;
            @(negedge clk);
        end
        chk("div1_ss_low", 32'(low1),   32'd17);
        chk("div1_rises",  32'(nrise1), 32'd8);
        chk("div1_mosi",   32'(bits1),  32'h81);
        chk("div1_rx",     32'(rx1),    32'hFF);
        chk("div1_dones",  32'(d1),     32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
